// File: rtl/btn_ctrl_udg_if.sv
// Button inputs and control outputs of the chronometer front-end, grouped as one port bundle.
interface btn_ctrl_udg_if;
  logic       btn_start;
  logic       btn_lap;
  logic       tick_o;
  logic       run_o;
  logic       freeze_o;
  logic       lap_o;
  logic       clr_o;
  logic [1:0] state_o;

  modport master (
    output btn_start, btn_lap,
    input  tick_o, run_o, freeze_o, lap_o, clr_o, state_o
  );

  modport slave (
    input  btn_start, btn_lap,
    output tick_o, run_o, freeze_o, lap_o, clr_o, state_o
  );
endinterface

// File: rtl/btn_ctrl_udg.sv
// Chronometer front-end: button sync/debounce, 10 ms time base, short/long lap
// classification and the mode FSM driving the counter stage.
module btn_ctrl_udg #(
  parameter int unsigned DIV        = 250000,
  parameter int unsigned DB_TICKS   = 3,
  parameter int unsigned LONG_TICKS = 100
) (
  input  logic          clk,
  input  logic          rst_n,
  btn_ctrl_udg_if.slave bus
);

  localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned DB_W   = $clog2(DB_TICKS + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_TICKS + 1);
  localparam int unsigned B_START = 0;
  localparam int unsigned B_LAP   = 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STOP = 2'b10,
    LAP  = 2'b11
  } state_t;

  // Time base; tick_q is high exactly while div_cnt == DIV-1
  logic [DIV_W-1:0] div_cnt;
  logic             tick_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      tick_q  <= 1'b0;
    end else begin
      div_cnt <= (div_cnt == DIV_W'(DIV - 1)) ? '0 : div_cnt + DIV_W'(1);
      tick_q  <= (div_cnt == DIV_W'(DIV - 2));
    end
  end

  logic [1:0] raw;
  logic [1:0] db;
  logic [1:0] db_d;

  assign raw = {bus.btn_lap, bus.btn_start};

  // Per-button two-flop synchroniser and tick-sampled debouncer
  for (genvar g = 0; g < 2; g++) begin : g_db
    logic            s1;
    logic            s2;
    logic            lvl;
    logic            lvl_d;
    logic [DB_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1    <= 1'b0;
        s2    <= 1'b0;
        lvl   <= 1'b0;
        lvl_d <= 1'b0;
        cnt   <= '0;
      end else begin
        s1    <= raw[g];
        s2    <= s1;
        lvl_d <= lvl;
        if (tick_q) begin
          if (s2 != lvl) begin
            if (cnt == DB_W'(DB_TICKS - 1)) begin
              lvl <= ~lvl;
              cnt <= '0;
            end else begin
              cnt <= cnt + DB_W'(1);
            end
          end else begin
            cnt <= '0;
          end
        end
      end
    end

    assign db[g]   = lvl;
    assign db_d[g] = lvl_d;
  end

  logic [1:0] press_c;
  logic [1:0] rel_c;
  logic       start_c;
  logic       long_c;
  logic       short_c;

  assign press_c = db & ~db_d;
  assign rel_c   = ~db & db_d;
  assign start_c = press_c[B_START];

  // Lap hold timer; long_done blocks a short event on release of a long press
  logic [HOLD_W-1:0] hold_cnt;
  logic              long_done;

  assign long_c  = (hold_cnt == HOLD_W'(LONG_TICKS)) && !long_done;
  assign short_c = rel_c[B_LAP] && !long_done && !long_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt  <= '0;
      long_done <= 1'b0;
    end else if (press_c[B_LAP]) begin
      hold_cnt  <= '0;
      long_done <= 1'b0;
    end else begin
      if (tick_q && db[B_LAP] && (hold_cnt != HOLD_W'(LONG_TICKS))) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
      if (long_c) begin
        long_done <= 1'b1;
      end
    end
  end

  state_t state;
  state_t state_n;
  logic   lap_n;
  logic   clr_n;
  logic   lap_q;
  logic   clr_q;
  logic   run_q;
  logic   freeze_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lap_q    <= 1'b0;
      clr_q    <= 1'b0;
      run_q    <= 1'b0;
      freeze_q <= 1'b0;
    end else begin
      state    <= state_n;
      lap_q    <= lap_n;
      clr_q    <= clr_n;
      run_q    <= (state_n == RUN) || (state_n == LAP);
      freeze_q <= (state_n == LAP);
    end
  end

  // Start always wins over a lap event arriving in the same cycle
  always_comb begin
    state_n = state;
    lap_n   = 1'b0;
    clr_n   = 1'b0;
    case (state)
      IDLE: begin
        if (start_c) state_n = RUN;
      end
      RUN: begin
        if (start_c) begin
          state_n = STOP;
        end else if (short_c) begin
          state_n = LAP;
          lap_n   = 1'b1;
        end
      end
      LAP: begin
        if (start_c) begin
          state_n = STOP;
        end else if (short_c) begin
          lap_n = 1'b1;
        end else if (long_c) begin
          state_n = RUN;
        end
      end
      STOP: begin
        if (start_c) begin
          state_n = RUN;
        end else if (long_c) begin
          state_n = IDLE;
          clr_n   = 1'b1;
        end
      end
    endcase
  end

  assign bus.tick_o   = tick_q;
  assign bus.run_o    = run_q;
  assign bus.freeze_o = freeze_q;
  assign bus.lap_o    = lap_q;
  assign bus.clr_o    = clr_q;
  assign bus.state_o  = state;

endmodule

// File: tb/tb_btn_ctrl_udg.sv
// Self-checking bench for btn_ctrl_udg: vector table of button steps with a scoreboard
// of expected mode/outputs, plus hand sequences for tick phase, glitches, collision and reset.
module tb_btn_ctrl_udg;
  localparam int unsigned DIV    = 4;
  localparam int unsigned DB     = 2;
  localparam int unsigned LONG   = 5;
  localparam int          SETTLE = 24;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  btn_ctrl_udg_if bus();

  btn_ctrl_udg #(.DIV(DIV), .DB_TICKS(DB), .LONG_TICKS(LONG)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    start_cyc;
    int    lap_cyc;
    int    st;
    int    run;
    int    frz;
    int    laps;
    int    clrs;
    int    lap_base;
    int    clr_base;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   lap_total = 0;
  int   clr_total = 0;
  vec_t sb_q[$];
  vec_t vecs[$];

  // Pulse monitor: counts high cycles, so a stretched pulse shows up as an extra count
  always @(negedge clk) begin
    if (bus.lap_o) lap_total++;
    if (bus.clr_o) clr_total++;
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  function automatic vec_t mk(input string nm, input int s, input int l, input int st,
                              input int run, input int frz, input int laps, input int clrs);
    vec_t v;
    v.name = nm; v.start_cyc = s; v.lap_cyc = l; v.st = st; v.run = run; v.frz = frz;
    v.laps = laps; v.clrs = clrs; v.lap_base = 0; v.clr_base = 0;
    return v;
  endfunction

  task automatic push_exp(input vec_t v);
    v.lap_base = lap_total;
    v.clr_base = clr_total;
    sb_q.push_back(v);
  endtask

  task automatic check_out();
    vec_t e;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      return;
    end
    e = sb_q.pop_front();
    chk({e.name, ".state"},  int'(bus.state_o),  e.st);
    chk({e.name, ".run"},    int'(bus.run_o),    e.run);
    chk({e.name, ".freeze"}, int'(bus.freeze_o), e.frz);
    chk({e.name, ".laps"},   lap_total - e.lap_base, e.laps);
    chk({e.name, ".clrs"},   clr_total - e.clr_base, e.clrs);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply(input vec_t v);
    push_exp(v);
    if (v.start_cyc > 0) begin
      bus.btn_start = 1'b1; cyc(v.start_cyc);
      bus.btn_start = 1'b0; cyc(SETTLE);
    end
    if (v.lap_cyc > 0) begin
      bus.btn_lap = 1'b1; cyc(v.lap_cyc);
      bus.btn_lap = 1'b0; cyc(SETTLE);
    end
    check_out();
  endtask

  initial begin
    int k;
    bus.btn_start = 1'b0;
    bus.btn_lap   = 1'b0;

    //              name          start lap  st run frz laps clrs
    vecs.push_back(mk("run1",        12,  0, 1, 1, 0, 0, 0));
    vecs.push_back(mk("stop1",       12,  0, 2, 0, 0, 0, 0));
    vecs.push_back(mk("run2",        12,  0, 1, 1, 0, 0, 0));
    vecs.push_back(mk("split1",       0, 12, 3, 1, 1, 1, 0));
    vecs.push_back(mk("split2",       0, 12, 3, 1, 1, 1, 0));
    vecs.push_back(mk("unsplit",      0, 36, 1, 1, 0, 0, 0));
    vecs.push_back(mk("stop2",       12,  0, 2, 0, 0, 0, 0));
    vecs.push_back(mk("stop_short",   0, 12, 2, 0, 0, 0, 0));
    vecs.push_back(mk("clear",        0, 36, 0, 0, 0, 0, 1));
    vecs.push_back(mk("idle_short",   0, 12, 0, 0, 0, 0, 0));
    vecs.push_back(mk("idle_long",    0, 36, 0, 0, 0, 0, 0));
    vecs.push_back(mk("run3",        12,  0, 1, 1, 0, 0, 0));
    vecs.push_back(mk("split3",       0, 12, 3, 1, 1, 1, 0));
    vecs.push_back(mk("lap_stop",    12,  0, 2, 0, 0, 0, 0));
    vecs.push_back(mk("run4",        12,  0, 1, 1, 0, 0, 0));

    // Reset values, then tick phase: first pulse after 3 edges, period 4
    cyc(3);
    chk("rst.state",  int'(bus.state_o),  0);
    chk("rst.run",    int'(bus.run_o),    0);
    chk("rst.freeze", int'(bus.freeze_o), 0);
    chk("rst.lap",    int'(bus.lap_o),    0);
    chk("rst.clr",    int'(bus.clr_o),    0);
    chk("rst.tick",   int'(bus.tick_o),   0);
    rst_n = 1'b1;
    #1;
    for (int n = 0; n < 12; n++) begin
      chk($sformatf("tick.c%0d", n), int'(bus.tick_o), (n % 4 == 3) ? 1 : 0);
      @(negedge clk);
    end

    foreach (vecs[i]) apply(vecs[i]);

    // Single 5-cycle glitch placed so that only one tick samples it
    k = 0;
    while (!bus.tick_o && k < 8) begin
      @(negedge clk);
      k++;
    end
    chk("glitch5.align", int'(bus.tick_o), 1);
    push_exp(mk("glitch5", 0, 0, 1, 1, 0, 0, 0));
    bus.btn_start = 1'b1; cyc(5);
    bus.btn_start = 1'b0; cyc(SETTLE);
    check_out();

    // 3-high/5-low bursts: two consecutive ticks can never both see the button high
    push_exp(mk("glitch_train", 0, 0, 1, 1, 0, 0, 0));
    repeat (5) begin
      bus.btn_start = 1'b1; cyc(3);
      bus.btn_start = 1'b0; cyc(5);
    end
    cyc(SETTLE);
    check_out();

    // Lap release and start press debounce on the same tick: start wins
    push_exp(mk("collision", 0, 0, 2, 0, 0, 0, 0));
    bus.btn_lap = 1'b1; cyc(12);
    bus.btn_lap = 1'b0;
    bus.btn_start = 1'b1; cyc(12);
    bus.btn_start = 1'b0; cyc(SETTLE);
    check_out();

    apply(mk("run5",   12, 0, 1, 1, 0, 0, 0));
    apply(mk("split4",  0, 12, 3, 1, 1, 1, 0));

    // Asynchronous reset while in LAP, sampled before the next rising edge
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst.state",  int'(bus.state_o),  0);
    chk("arst.run",    int'(bus.run_o),    0);
    chk("arst.freeze", int'(bus.freeze_o), 0);
    chk("arst.tick",   int'(bus.tick_o),   0);
    cyc(2);
    rst_n = 1'b1;
    push_exp(mk("post_rst", 0, 0, 0, 0, 0, 0, 0));
    cyc(SETTLE);
    check_out();
    apply(mk("run6", 12, 0, 1, 1, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
